// File: rtl/bcd_time_decoder.sv
// -----------------------------------------------------------------------------
// bcd_time_decoder
//
// Sequential binary-to-BCD converter for time-display fields, such as
// minutes:seconds. It converts every field in parallel using shift-add-3
// (double-dabble) and processes one input bit per clock.
//
// Optional feature:
//   BCD_LEAD_ZERO_BLANK_EN - when defined, each leading zero digit above the
//   highest nonzero digit of a field is output as 4'hF. The display driver
//   decodes 4'hF as a dark digit. Digit 0 is never blanked, and saturated
//   fields always show all 9s.
//
// Ports:
//   clk        - system clock
//   nrst       - asynchronous active-low reset
//   start      - conversion request, sampled only while the FSM is idle
//   value_in   - packed binary fields, field f = value_in[f*FIELD_W +: FIELD_W]
//   busy       - high while a conversion is in progress
//   done       - one-cycle pulse when digits_out/overflow update
//   digits_out - BCD digit d of field f at [(f*DIGITS+d)*4 +: 4], d=0 is ones
//   overflow   - bit f set if field f exceeded 10^DIGITS-1 on last conversion
// -----------------------------------------------------------------------------
module bcd_time_decoder #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 6,
  parameter int DIGITS     = 2
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           start,
  input  logic [NUM_FIELDS*FIELD_W-1:0]  value_in,
  output logic                           busy,
  output logic                           done,
  output logic [NUM_FIELDS*DIGITS*4-1:0] digits_out,
  output logic [NUM_FIELDS-1:0]          overflow
);

  // The scratch area carries one spare nibble above the visible digits, so
  // large inputs never wrap into the visible digits unnoticed.
  localparam int BCDW = (DIGITS + 1) * 4;
  localparam int OUTW = DIGITS * 4;
  localparam int CW   = $clog2(FIELD_W + 1);

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 32'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 32'd10;
    end
    return r;
  endfunction

  localparam int unsigned MAX_V = pow10(DIGITS) - 32'd1;

  // Each step adds 3 to every nibble >= 5, then shifts left and brings in
  // the next input bit. Input bits are taken MSB first.
  function automatic logic [BCDW-1:0] dabble_step(input logic [BCDW-1:0] bcd,
                                                  input logic            in_bit);
    logic [BCDW-1:0] adj;
    for (int n = 0; n < DIGITS + 1; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        adj[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return (adj << 1) | {{(BCDW-1){1'b0}}, in_bit};
  endfunction

  // Formats the digits for one field. A saturated field shows all 9s.
  // Optional leading-zero blanking is also applied here.
  function automatic logic [OUTW-1:0] format_digits(input logic [OUTW-1:0] bcd,
                                                    input logic            sat);
    logic [OUTW-1:0] res;
`ifdef BCD_LEAD_ZERO_BLANK_EN
    logic lead;
`endif
    if (sat) begin
      res = {DIGITS{4'd9}};
    end else begin
      res = bcd;
`ifdef BCD_LEAD_ZERO_BLANK_EN
      lead = 1'b1;
      for (int n = DIGITS - 1; n >= 1; n--) begin
        if (lead && (bcd[n*4 +: 4] == 4'd0)) begin
          res[n*4 +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
`endif
    end
    return res;
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t                         state_r;
  state_t                         state_nx_s;
  logic                           accept_s;
  logic                           last_s;
  logic [CW-1:0]                  cnt_r;
  logic [FIELD_W-1:0]             sh_r       [NUM_FIELDS];
  logic [BCDW-1:0]                bcd_r      [NUM_FIELDS];
  logic [FIELD_W-1:0]             field_s    [NUM_FIELDS];
  logic [FIELD_W-1:0]             sh_step_s  [NUM_FIELDS];
  logic [BCDW-1:0]                bcd_step_s [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]          sat_s;
  logic [NUM_FIELDS-1:0]          sat_r;
  logic                           fin_r;
  logic                           busy_r;
  logic                           done_r;
  logic [NUM_FIELDS*OUTW-1:0]     digits_nx_s;
  logic [NUM_FIELDS*OUTW-1:0]     digits_r;
  logic [NUM_FIELDS-1:0]          overflow_r;

  // Next-state logic: accept start while idle, and stop after the last shift.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = ST_CONV;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CONV: begin
        if (cnt_r == CW'(FIELD_W - 1)) begin
          state_nx_s = ST_IDLE;
          last_s     = 1'b1;
        end else begin
          state_nx_s = ST_CONV;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Per-field datapath: field slicing, saturation check, dabble step and
  // output formatting.
  always_comb begin
    sat_s       = '0;
    digits_nx_s = '0;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      field_s[f]    = value_in[f*FIELD_W +: FIELD_W];
      sat_s[f]      = (32'(field_s[f]) > MAX_V);
      bcd_step_s[f] = dabble_step(bcd_r[f], sh_r[f][FIELD_W-1]);
      sh_step_s[f]  = sh_r[f] << 1;
      digits_nx_s[f*OUTW +: OUTW] = format_digits(bcd_r[f][OUTW-1:0], sat_r[f]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Conversion scratch: capture on start, then shift once per CONV cycle.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        sh_r[f]  <= '0;
        bcd_r[f] <= '0;
      end
      cnt_r <= '0;
      sat_r <= '0;
    end else if (accept_s) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        sh_r[f]  <= field_s[f];
        bcd_r[f] <= '0;
      end
      cnt_r <= '0;
      sat_r <= sat_s;
    end else if (state_r == ST_CONV) begin
      for (int f = 0; f < NUM_FIELDS; f++) begin
        sh_r[f]  <= sh_step_s[f];
        bcd_r[f] <= bcd_step_s[f];
      end
      cnt_r <= cnt_r + CW'(1);
    end
  end

  // Handshake and output registers. The outputs load one edge after the last
  // shift. busy covers that extra cycle, unless a new start is accepted on the
  // same edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fin_r      <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      digits_r   <= '0;
      overflow_r <= '0;
    end else begin
      fin_r  <= last_s;
      busy_r <= accept_s | (state_r == ST_CONV);
      if (fin_r) begin
        done_r     <= 1'b1;
        digits_r   <= digits_nx_s;
        overflow_r <= sat_r;
      end else begin
        done_r <= 1'b0;
      end
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign digits_out = digits_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_bcd_time_decoder.sv
// -----------------------------------------------------------------------------
// tb_bcd_time_decoder
//
// Scoreboard bench with two instances.
//   dut  - default parameters: two fields of 6 bits, 2 digits each.
//   dut2 - one field of 7 bits, 2 digits; exercises saturation.
// The stimulus pushes expected results, including the expected done cycle.
// Per-instance monitors pop and compare whenever done is seen.
// -----------------------------------------------------------------------------
module tb_bcd_time_decoder;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  o;
    int          c;
  } exp_t;

`ifdef BCD_LEAD_ZERO_BLANK_EN
  localparam logic [15:0] EXP_047 = 16'hF1F7;
  localparam logic [15:0] EXP_000 = 16'hF0F0;
`else
  localparam logic [15:0] EXP_047 = 16'h0107;
  localparam logic [15:0] EXP_000 = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        start;
  logic [11:0] value_in;
  logic        busy;
  logic        done;
  logic [15:0] digits_out;
  logic [1:0]  overflow;

  logic        start2;
  logic [6:0]  value2;
  logic        busy2;
  logic        done2;
  logic [7:0]  digits2;
  logic [0:0]  ovf2;

  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  exp_t q  [$];
  exp_t q2 [$];
  exp_t mon_e;
  exp_t mon_e2;

  bcd_time_decoder dut (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start),
    .value_in   (value_in),
    .busy       (busy),
    .done       (done),
    .digits_out (digits_out),
    .overflow   (overflow)
  );

  bcd_time_decoder #(.NUM_FIELDS(1), .FIELD_W(7), .DIGITS(2)) dut2 (
    .clk        (clk),
    .nrst       (nrst),
    .start      (start2),
    .value_in   (value2),
    .busy       (busy2),
    .done       (done2),
    .digits_out (digits2),
    .overflow   (ovf2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic push(input logic [15:0] d, input logic [1:0] o, input int c);
    exp_t e;
    e.d = d;
    e.o = o;
    e.c = c;
    q.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Called at a negedge. The start edge is the next posedge, and done is
  // visible FIELD_W+1 = 7 cycles after it.
  task automatic issue(input logic [11:0] v, input logic [15:0] d, input logic [1:0] o);
    value_in = v;
    start    = 1'b1;
    push(d, o, cyc + 8);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue2(input logic [6:0] v, input logic [7:0] d, input logic o);
    exp_t e;
    value2 = v;
    start2 = 1'b1;
    e.d = {8'h00, d};
    e.o = {1'b0, o};
    e.c = cyc + 9;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // Monitor for dut.
  always @(negedge clk) begin
    if (nrst && done) begin
      done_cnt++;
      check("done_expected", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("digits", {16'd0, digits_out}, {16'd0, mon_e.d});
        check("overflow", {30'd0, overflow}, {30'd0, mon_e.o});
        check("done_cycle", cyc, mon_e.c);
      end
    end
  end

  // Monitor for dut2.
  always @(negedge clk) begin
    if (nrst && done2) begin
      check("done2_expected", {31'd0, (q2.size() != 0)}, 32'd1);
      if (q2.size() != 0) begin
        mon_e2 = q2.pop_front();
        check("digits2", {24'd0, digits2}, {16'd0, mon_e2.d});
        check("overflow2", {31'd0, ovf2}, {30'd0, mon_e2.o});
        check("done2_cycle", cyc, mon_e2.c);
      end
    end
  end

  initial begin
    int n;
    int dc;
    nrst     = 1'b0;
    start    = 1'b0;
    value_in = 12'h000;
    start2   = 1'b0;
    value2   = 7'd0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_digits", {16'd0, digits_out}, 32'd0);
    check("rst_overflow", {30'd0, overflow}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    wait_cycles(2);

    // Basic conversion 45:07, with the busy window checked.
    issue(12'hB47, 16'h4507, 2'b00);
    for (int i = 0; i < 7; i++) begin
      check("busy_high", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("busy_low", {31'd0, busy}, 32'd0);
    wait_cycles(3);

    // A start pulse while busy must be ignored.
    issue(12'hB47, 16'h4507, 2'b00);
    wait_cycles(2);
    value_in = 12'h000;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cycles(12);

    // Asynchronous reset in the middle of a conversion.
    issue(12'h3C5, 16'h1505, 2'b00);
    wait_cycles(2);
    nrst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_digits", {16'd0, digits_out}, 32'd0);
    check("midrst_overflow", {30'd0, overflow}, 32'd0);
    q.delete();
    wait_cycles(2);
    nrst = 1'b1;
    dc = done_cnt;
    wait_cycles(15);
    check("no_done_after_reset", done_cnt, dc);

    // Start held high: back-to-back conversions with a period of 7 cycles.
    // value_in changes during the third conversion and must only affect the
    // fourth conversion.
    n = cyc;
    value_in = 12'hFFF;
    start    = 1'b1;
    push(16'h6363, 2'b00, n + 8);
    push(16'h6363, 2'b00, n + 15);
    push(16'h6363, 2'b00, n + 22);
    wait_until(n + 17);
    value_in = 12'h000;
    push(EXP_000, 2'b00, n + 29);
    wait_until(n + 22);
    start = 1'b0;
    wait_cycles(10);

    // Leading-zero handling (blanked or plain, depending on the build).
    issue(12'h047, EXP_047, 2'b00);
    wait_cycles(8);
    issue(12'h000, EXP_000, 2'b00);
    wait_cycles(8);

    // Saturation boundaries on the 7-bit field.
    issue2(7'd120, 8'h99, 1'b1);
    wait_cycles(9);
    issue2(7'd99, 8'h99, 1'b0);
    wait_cycles(9);
    issue2(7'd100, 8'h99, 1'b1);
    wait_cycles(9);
    issue2(7'd58, 8'h58, 1'b0);
    wait_cycles(9);

    // Drain with a bound.
    for (int i = 0; i < 100 && (q.size() + q2.size()) != 0; i++) @(negedge clk);
    check("drain", q.size() + q2.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
